// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: sequencer state encodings, register zero and
// the opcodes the control unit decodes into MemRead/MemWrite.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Upstream decode of dmem_req uses this so it matches the control unit.
  function automatic logic is_mem_op(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/mips_hazard_detect.sv
// Load-use hazard detector: an EX-stage load whose destination feeds the ID-stage
// instruction. Purely combinational so the forwarding unit can reuse it.
module mips_hazard_detect
  import mips_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic [REG_W-1:0] rt_ex,
  input  logic             memread_ex,
  output logic             load_use
);

  // Writes to $zero never create a dependency.
  assign load_use = memread_ex && (rt_ex != REG_W'(REG_ZERO)) &&
                    ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/mips_pipeline_sequencer.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and a
// data-memory wait freeze, plus a stall-cycle counter and a sticky timeout flag.
module mips_pipeline_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             memread_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout_err,
  output logic [1:0]       state
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             err_q, err_d;

  logic load_use;
  logic freeze;
  logic branch_eff;

  mips_hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .rs_id     (rs_id),
    .rt_id     (rt_id),
    .rt_ex     (rt_ex),
    .memread_ex(memread_ex),
    .load_use  (load_use)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    unique case (state_q)
      ST_RUN:      state_d = freeze ? ST_MEM_WAIT : (branch_eff ? ST_FLUSH : ST_RUN);
      ST_FLUSH:    state_d = freeze ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT: state_d = freeze ? ST_MEM_WAIT : ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    // Wait count is the number of frozen cycles in the current access.
    wait_d = '0;
    if (freeze) begin
      if (state_q != ST_MEM_WAIT) begin
        wait_d = WaitW'(1);
      end else if (wait_q < WaitW'(MEM_TIMEOUT)) begin
        wait_d = wait_q + WaitW'(1);
      end else begin
        wait_d = wait_q;
      end
    end
    err_d = err_q || (freeze && (wait_d == WaitW'(MEM_TIMEOUT)));

    stall_d = stall_q;
    if (!pc_write && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    freeze     = 1'b0;
    branch_eff = branch_taken_ex;
    unique case (state_q)
      ST_RUN:      freeze = dmem_req && !dmem_ack;
      ST_FLUSH: begin
        freeze     = dmem_req && !dmem_ack;
        branch_eff = 1'b0;
      end
      // The held access stays in MEM until it is acknowledged.
      ST_MEM_WAIT: freeze = !(dmem_req && dmem_ack);
      default: begin
        freeze     = 1'b0;
        branch_eff = 1'b0;
      end
    endcase

    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    pipe_hold    = 1'b0;
    memwb_bubble = 1'b0;
    if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      pipe_hold    = 1'b1;
      memwb_bubble = 1'b1;
    end else if (branch_eff) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign stall_cycles    = stall_q;
  assign mem_timeout_err = err_q;
  assign state           = state_q;

endmodule

// File: tb/tb_mips_pipeline_sequencer.sv
// Bench for mips_pipeline_sequencer: directed scenarios then random stimulus, all
// checked against a cycle-level reference model of the sequencing rules.
module tb_mips_pipeline_sequencer;

  localparam int unsigned TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_id, rt_id, rt_ex;
  logic       memread_ex, branch_taken_ex, dmem_req, dmem_ack;

  logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush;
  logic        pipe_hold, memwb_bubble, mem_timeout_err;
  logic [15:0] stall_cycles;
  logic [1:0]  state;

  logic        s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush, s_idex_flush;
  logic        s_pipe_hold, s_memwb_bubble, s_mem_timeout_err;
  logic [1:0]  s_stall_cycles;
  logic [1:0]  s_state;

  mips_pipeline_sequencer #(.REG_W(5), .CNT_W(16), .MEM_TIMEOUT(TMO)) u_dut (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .memread_ex(memread_ex),
    .rt_ex(rt_ex), .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pipe_hold(pipe_hold), .memwb_bubble(memwb_bubble), .stall_cycles(stall_cycles),
    .mem_timeout_err(mem_timeout_err), .state(state)
  );

  mips_pipeline_sequencer #(.REG_W(5), .CNT_W(2), .MEM_TIMEOUT(TMO)) u_dut_sat (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .memread_ex(memread_ex),
    .rt_ex(rt_ex), .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .pipe_hold(s_pipe_hold), .memwb_bubble(s_memwb_bubble), .stall_cycles(s_stall_cycles),
    .mem_timeout_err(s_mem_timeout_err), .state(s_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: what the pipeline is doing, not how the RTL encodes it.
  bit m_wait, m_flush, m_err;
  int m_wlen, m_stall;

  function automatic int unsigned clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_wait = 0; m_flush = 0; m_err = 0; m_wlen = 0; m_stall = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_state", {30'd0, state}, 0);
    check("rst_err", {31'd0, mem_timeout_err}, 0);
    check("rst_stall", {16'd0, stall_cycles}, 0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic cycle(input logic mr, input logic [4:0] rte, input logic [4:0] rsi,
                       input logic [4:0] rti, input logic br, input logic rq, input logic ak);
    bit luse, frz, br_e;
    logic [6:0] exp;
    memread_ex = mr; rt_ex = rte; rs_id = rsi; rt_id = rti;
    branch_taken_ex = br; dmem_req = rq; dmem_ack = ak;
    @(negedge clk);
    luse = mr && (rte != 0) && (rte == rsi || rte == rti);
    frz  = m_wait ? !(rq && ak) : (rq && !ak);
    br_e = br && !m_flush;
    // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold, memwb_bubble}
    if (frz)       exp = 7'b0000011;
    else if (br_e) exp = 7'b1101100;
    else if (luse) exp = 7'b0010000;
    else           exp = 7'b1100000;
    check("outs", {25'd0, pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
                   pipe_hold, memwb_bubble}, {25'd0, exp});
    check("sat_outs", {25'd0, s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush,
                       s_idex_flush, s_pipe_hold, s_memwb_bubble}, {25'd0, exp});
    check("state", {30'd0, state}, m_wait ? 1 : (m_flush ? 2 : 0));
    check("stall", {16'd0, stall_cycles}, clip(m_stall, 65535));
    check("stall_sat", {30'd0, s_stall_cycles}, clip(m_stall, 3));
    check("err", {31'd0, mem_timeout_err}, {31'd0, m_err});
    if (frz) begin
      m_wlen = m_wait ? clip(m_wlen + 1, TMO) : 1;
      if (m_wlen >= TMO) m_err = 1;
    end else begin
      m_wlen = 0;
    end
    m_flush = !frz && !m_wait && br_e;
    m_wait  = frz;
    if (!exp[6]) m_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    memread_ex = 0; rt_ex = 0; rs_id = 0; rt_id = 0;
    branch_taken_ex = 0; dmem_req = 0; dmem_ack = 0;
    do_reset();

    cycle(0, 0, 0, 0, 0, 0, 0);
    check("idle_pc", {31'd0, pc_write}, 1);

    cycle(1, 8, 8, 0, 0, 0, 0);
    check("luse_stall", {16'd0, stall_cycles}, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("rt0_nostall", {16'd0, stall_cycles}, 1);

    cycle(1, 8, 8, 0, 1, 0, 0);
    check("br_flush_state", {30'd0, state}, 2);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("br_back_run", {30'd0, state}, 0);

    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 1);
    check("memwait_stall", {16'd0, stall_cycles}, 3);

    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    check("timeout_set", {31'd0, mem_timeout_err}, 1);
    cycle(0, 0, 0, 0, 0, 1, 1);
    check("timeout_sticky", {31'd0, mem_timeout_err}, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    do_reset();

    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    check("sat_at_3", {30'd0, s_stall_cycles}, 3);
    cycle(0, 0, 0, 0, 0, 1, 1);

    for (int i = 0; i < 400; i++) begin
      logic rq, ak;
      if ($urandom_range(0, 99) == 0) do_reset();
      rq = m_wait ? 1'b1 : ($urandom_range(0, 9) < 3);
      ak = ($urandom_range(0, 9) < 3);
      cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, rq, ak);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_pipeline_sequencer.md
Name: mips_pipeline_sequencer

Overview:
Pipeline sequencing controller for the 5-stage MIPS pipeline. It takes hazard-relevant fields from ID, EX and MEM and drives the stage-register write enables, bubble inserts and flushes. It covers three cases: load-use stalls, taken-branch flushes, and a variable-latency data-memory handshake freeze. It sits beside the control unit and gates the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.

Parameters:
REG_W, 5, register specifier width
CNT_W, 16, width of stall-cycle performance counter
MEM_TIMEOUT, 64, MEM_WAIT cycles before timeout error flags (>=1)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
rs_id  input  REG_W  rs field of instruction in ID
rt_id  input  REG_W  rt field of instruction in ID
memread_ex  input  1  MemRead of instruction in EX
rt_ex  input  REG_W  destination (rt) of instruction in EX
branch_taken_ex  input  1  branch resolved taken in EX this cycle
dmem_req  input  1  MEM-stage instruction accesses data memory (MemRead|MemWrite)
dmem_ack  input  1  data memory completes access this cycle
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
idex_bubble  output  1  zero control signals entering ID/EX
ifid_flush  output  1  clear IF/ID to NOP
idex_flush  output  1  clear ID/EX to NOP
pipe_hold  output  1  hold ID/EX and EX/MEM (no load)
memwb_bubble  output  1  load NOP into MEM/WB
stall_cycles  output  CNT_W  saturating count of cycles with pc_write=0
mem_timeout_err  output  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT
state  output  2  current FSM state (debug)

Behaviour:
- Reset (async, active-high): state=RUN, wait counter=0, stall_cycles=0, mem_timeout_err=0. Outputs settle to RUN/no-hazard values: pc_write=1, ifid_write=1, all others 0.
- States: RUN=2'b00, MEM_WAIT=2'b01, FLUSH=2'b10. Encoding 2'b11 is illegal and returns to RUN next cycle with RUN outputs.
- Outputs are Mealy (combinational from state and inputs). State, counters and error flag are registered.
- Load-use hazard: load_use = memread_ex && rt_ex!=0 && (rt_ex==rs_id || rt_ex==rt_id).
- Decision priority in RUN, highest first:
  1. mem_freeze = dmem_req && !dmem_ack. Drive pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1. Next state MEM_WAIT, wait counter set to 1. Branch and load-use are ignored because the held registers re-present them later.
  2. branch_taken_ex. Drive ifid_flush=1 and idex_flush=1; pc_write=1 (PC takes the target), ifid_write=1. Next state FLUSH.
  3. load_use. Drive pc_write=0, ifid_write=0, idex_bubble=1 for exactly this cycle; state stays RUN. The bubble advances, so load_use is naturally false next cycle.
  4. Otherwise all enables are 1 and all flushes/bubbles are 0.
- FLUSH lasts exactly one cycle and is an observation/debug state. Outputs are evaluated with the same priority as RUN, except that branch_taken_ex is masked to 0, since the EX instruction was flushed. Next state is RUN, or MEM_WAIT if mem_freeze.
- MEM_WAIT:
  - Outputs stay frozen as in case 1 while !dmem_ack.
  - When dmem_ack=1: outputs become RUN values this cycle, with normal priority applied. Next state RUN and the wait counter clears.
  - While waiting, the wait counter increments each cycle and saturates at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, mem_timeout_err sets and stays set until reset. The FSM keeps waiting; there is no abort.
- Ack on the same cycle as req in RUN means no freeze (zero-wait memory).
- dmem_ack without dmem_req is ignored.
- stall_cycles increments on every clock where pc_write=0 and saturates at 2^CNT_W-1.
- Reset mid-MEM_WAIT or mid-stall returns to RUN immediately; there is no pending state.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings ST_RUN, ST_MEM_WAIT, ST_FLUSH
  - REG_ZERO constant (5'd0)
  - opcode constants already used by the control unit (OP_RTYPE, OP_LW, OP_SW, OP_BEQ), so upstream decode of dmem_req is consistent
- One natural sub-module: mips_hazard_detect. It is purely combinational, computing load_use from rs_id/rt_id/rt_ex/memread_ex, and is reusable by the forwarding unit.
- The FSM, wait counter and performance counter stay in the top module.

Test Plan:
- Reset then idle inputs (all 0) -> pc_write=1, ifid_write=1, all flushes/bubbles 0, state=00, stall_cycles=0.
- memread_ex=1, rt_ex=5'd8, rs_id=5'd8 for 1 cycle -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle all normal; stall_cycles=1. Repeat with rt_ex=0 -> no stall.
- branch_taken_ex=1 together with a load_use match -> ifid_flush=1, idex_flush=1, pc_write=1, idex_bubble=0; next cycle state=10 with a held branch_taken_ex ignored; then state=00.
- dmem_req=1, dmem_ack=0 for 3 cycles, then ack=1 -> pc_write=0, pipe_hold=1, memwb_bubble=1 for 3 cycles, state=01; normal on the ack cycle; stall_cycles=3.
- MEM_TIMEOUT=4, dmem_req=1 with no ack for 6 cycles -> mem_timeout_err rises once the wait count reaches 4, stays 1 after ack; assert reset mid-wait -> state=00, err=0 immediately (asynchronous).
- CNT_W=2, 5 consecutive freeze cycles -> stall_cycles saturates at 3.
